// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: decodes SPI command frames (WRITE/READ/NOP) into memory write/read
// strobes, with frame abort on idle timeout and error pulses for malformed frames.
`default_nettype none

module spi_cmd_parser #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              frame_end,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              err,
  output logic [15:0]       cmd_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WDATA   = 3'd2,
    S_RDATA   = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              is_read, is_read_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic [TW-1:0]     tcnt;
  logic              timeout_hit;
  logic              wr_nx, rd_nx, err_nx, cnt_inc;
  logic              rd_dly;

  assign busy        = (state != S_IDLE);
  assign timeout_hit = (state != S_IDLE) && !rx_valid && (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx   = state;
    is_read_nx = is_read;
    ptr_nx     = ptr;
    wr_nx      = 1'b0;
    rd_nx      = 1'b0;
    err_nx     = 1'b0;
    cnt_inc    = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h01: begin state_nx = S_ADDR; is_read_nx = 1'b0; cnt_inc = 1'b1; end
            8'h02: begin state_nx = S_ADDR; is_read_nx = 1'b1; cnt_inc = 1'b1; end
            8'h00: state_nx = S_DISCARD;
            default: begin state_nx = S_DISCARD; err_nx = 1'b1; end
          endcase
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          ptr_nx = rx_data[ADDR_W-1:0];
          if (is_read) begin
            state_nx = S_RDATA;
            rd_nx    = 1'b1;
          end else begin
            state_nx = S_WDATA;
          end
        end else if (frame_end) begin
          // frame closed before an address arrived
          err_nx = 1'b1;
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          wr_nx  = 1'b1;
          ptr_nx = ptr + ADDR_W'(1);
        end
      end
      S_RDATA: begin
        if (rx_valid) begin
          ptr_nx = ptr + ADDR_W'(1);
          rd_nx  = 1'b1;
        end
      end
      S_DISCARD: ;
      default: state_nx = S_IDLE;
    endcase

    if (frame_end || timeout_hit) state_nx = S_IDLE;
    if (timeout_hit) err_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      is_read <= 1'b0;
      ptr     <= '0;
      tcnt    <= '0;
    end else begin
      state   <= state_nx;
      is_read <= is_read_nx;
      ptr     <= ptr_nx;
      if (state == S_IDLE || rx_valid || timeout_hit) tcnt <= '0;
      else                                            tcnt <= tcnt + TW'(1);
    end
  end

  // Write address is the pre-increment pointer; read address is the updated one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_dly    <= 1'b0;
      tx_data   <= '0;
      err       <= 1'b0;
      cmd_count <= '0;
    end else begin
      wr_en  <= wr_nx;
      rd_en  <= rd_nx;
      err    <= err_nx;
      rd_dly <= rd_en;
      if (wr_nx) begin
        wr_addr <= ptr;
        wr_data <= rx_data;
      end
      if (rd_nx)   rd_addr   <= ptr_nx;
      if (rd_dly)  tx_data   <= rd_data;
      if (cnt_inc) cmd_count <= cmd_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_parser.sv
// tb_spi_cmd_parser: directed frame table, random frames against a frame-level model,
// plus timeout and mid-frame reset sequences.
`default_nettype none

module tb_spi_cmd_parser;

  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          frame_end = 1'b0;
  logic          wr_en, rd_en, busy, err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data, tx_data;
  logic [7:0]    rd_data = 8'h00;
  logic [15:0]   cmd_count;

  int total = 0;
  int bad = 0;

  spi_cmd_parser #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .frame_end(frame_end), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data),
    .busy(busy), .err(err), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory with data one cycle after rd_en.
  logic [7:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  logic [15:0] wr_obs[$];
  logic [7:0]  rd_obs[$];
  int          err_obs = 0;
  logic        wr_prev = 1'b0, rd_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (wr_en) wr_obs.push_back({wr_addr, wr_data});
    if (rd_en) rd_obs.push_back(rd_addr);
    if (err) err_obs++;
    if ((wr_en && wr_prev) || (rd_en && rd_prev) || (err && err_prev)) begin
      bad++;
      $display("FAIL strobe_width: wr=%b rd=%b err=%b held for 2 cycles", wr_en, rd_en, err);
    end
    wr_prev  <= wr_en;
    rd_prev  <= rd_en;
    err_prev <= err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fe);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b; frame_end = fe;
    @(negedge clk);
    rx_valid = 1'b0; frame_end = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_fe();
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  int exp_cnt = 0;

  // Frame-level model: what a whole frame of bytes must produce.
  task automatic run_frame(input logic [7:0] b [8], input int n, input bit fel,
                           output int nw, output int nr, output int ne,
                           output logic [15:0] last_w, output logic [7:0] last_tx);
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_obs[$];
    logic [7:0]  ad;
    int exp_err, wb, rb, eb;
    wb = wr_obs.size(); rb = rd_obs.size(); eb = err_obs;
    if (b[0] == 8'h01)
      for (int i = 2; i < n; i++) begin
        ad = b[1] + 8'(i - 2);
        exp_wr.push_back({ad, b[i]});
      end
    if (b[0] == 8'h02 && n >= 2)
      for (int k = 0; k < n - 1; k++) begin
        ad = b[1] + 8'(k);
        exp_rd.push_back(ad);
        exp_tx.push_back(mem[ad]);
      end
    exp_err = (b[0] > 8'h02) ? 1 : ((b[0] != 8'h00 && n == 1 && !fel) ? 1 : 0);
    if (b[0] == 8'h01 || b[0] == 8'h02) exp_cnt = (exp_cnt + 1) & 16'hFFFF;

    for (int i = 0; i < n; i++) begin
      if (b[0] == 8'h02 && i >= 2) tx_obs.push_back(tx_data);
      send_byte(b[i], fel && (i == n - 1));
    end
    if (!fel) pulse_fe();
    repeat (4) @(negedge clk);
    if (b[0] == 8'h02 && n >= 2) tx_obs.push_back(tx_data);

    nw = wr_obs.size() - wb;
    nr = rd_obs.size() - rb;
    ne = err_obs - eb;
    last_w  = (nw > 0) ? wr_obs[wr_obs.size() - 1] : 16'h0;
    last_tx = tx_data;

    check("model_wr_count", nw, exp_wr.size());
    for (int j = 0; j < nw && j < exp_wr.size(); j++) check("model_wr", wr_obs[wb + j], exp_wr[j]);
    check("model_rd_count", nr, exp_rd.size());
    for (int j = 0; j < nr && j < exp_rd.size(); j++) check("model_rd_addr", rd_obs[rb + j], exp_rd[j]);
    for (int j = 0; j < exp_tx.size(); j++) check("model_tx", tx_obs[j], exp_tx[j]);
    check("model_err", ne, exp_err);
    check("cmd_count", cmd_count, exp_cnt);
    check("busy_after_frame", busy, 0);
  endtask

  typedef struct {
    int          n;
    logic [63:0] bytes;
    bit          fel;
    int          nw, nr, ne;
    logic [15:0] last_w;
    logic [7:0]  last_tx;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [63:0] by, input bit fel,
                              input int nw, input int nr, input int ne,
                              input logic [15:0] lw, input logic [7:0] ltx);
    vec_t v;
    v.n = n; v.bytes = by; v.fel = fel; v.nw = nw; v.nr = nr; v.ne = ne;
    v.last_w = lw; v.last_tx = ltx;
    return v;
  endfunction

  initial begin
    vec_t        tbl [8];
    logic [7:0]  b [8];
    int          nw, nr, ne, base;
    logic [15:0] lw;
    logic [7:0]  ltx;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'hFE] = 8'h5A; mem[8'hFF] = 8'hC3; mem[8'h00] = 8'h77;

    tbl[0] = mk(4, 64'h01_10_AA_BB_00000000, 0, 2, 0, 0, 16'h11BB, 8'h00);
    tbl[1] = mk(4, 64'h02_FE_00_00_00000000, 0, 0, 3, 0, 16'h0000, 8'h77);
    tbl[2] = mk(4, 64'h7F_01_02_03_00000000, 0, 0, 0, 1, 16'h0000, 8'h00);
    tbl[3] = mk(3, 64'h01_30_99_00_00000000, 1, 1, 0, 0, 16'h3099, 8'h00);
    tbl[4] = mk(4, 64'h00_01_02_03_00000000, 0, 0, 0, 0, 16'h0000, 8'h00);
    tbl[5] = mk(1, 64'h01_00_00_00_00000000, 0, 0, 0, 1, 16'h0000, 8'h00);
    tbl[6] = mk(2, 64'h02_40_00_00_00000000, 1, 0, 1, 0, 16'h0000, 8'h4B);
    tbl[7] = mk(1, 64'h02_00_00_00_00000000, 1, 0, 0, 0, 16'h0000, 8'h00);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_strobes", {wr_en, rd_en, err, busy}, 4'b0);
    check("reset_regs", {wr_addr, wr_data, rd_addr, tx_data}, 32'h0);
    check("reset_cmd_count", cmd_count, 16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) b[i] = tbl[t].bytes[63 - 8*i -: 8];
      run_frame(b, tbl[t].n, tbl[t].fel, nw, nr, ne, lw, ltx);
      check($sformatf("tbl%0d_wr", t), nw, tbl[t].nw);
      check($sformatf("tbl%0d_rd", t), nr, tbl[t].nr);
      check($sformatf("tbl%0d_err", t), ne, tbl[t].ne);
      if (tbl[t].nw > 0) check($sformatf("tbl%0d_last_wr", t), lw, tbl[t].last_w);
      if (tbl[t].nr > 0) check($sformatf("tbl%0d_tx", t), ltx, tbl[t].last_tx);
    end

    // Random frames
    for (int r = 0; r < 40; r++) begin
      int op, n;
      bit fel;
      op  = $urandom_range(0, 3);
      n   = $urandom_range(1, 7);
      fel = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
      b[0] = (op == 3) ? 8'($urandom) : 8'(op);
      run_frame(b, n, fel, nw, nr, ne, lw, ltx);
    end

    // Idle timeout aborts an open write frame
    base = err_obs;
    send_byte(8'h01, 0);
    send_byte(8'h20, 0);
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    repeat (TO - 8) @(negedge clk);
    check("timeout_not_early", err_obs - base, 0);
    check("timeout_busy_before", busy, 1);
    for (int c = 0; c < 20 && err_obs == base; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("timeout_err", err_obs - base, 1);
    check("timeout_busy_after", busy, 0);
    b[0] = 8'h01; b[1] = 8'h50; b[2] = 8'h66;
    run_frame(b, 3, 0, nw, nr, ne, lw, ltx);
    check("after_timeout_wr", lw, 16'h5066);

    // Reset in the middle of a write burst
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_strobes", {wr_en, rd_en, err, busy}, 4'b0);
    check("midrst_regs", {wr_addr, wr_data, rd_addr, tx_data}, 32'h0);
    check("midrst_cmd_count", cmd_count, 16'h0);
    exp_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = wr_obs.size() + rd_obs.size() + err_obs;
    repeat (10) @(negedge clk);
    check("midrst_quiet", wr_obs.size() + rd_obs.size() + err_obs - base, 0);
    b[0] = 8'h01; b[1] = 8'h60; b[2] = 8'h77;
    run_frame(b, 3, 1, nw, nr, ne, lw, ltx);
    check("after_reset_wr", lw, 16'h6077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_cmd_parser.md
SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 1024, idle system-clock cycles before an open frame is aborted (>=4).
REQ-003 SHALL have port clk  input  1  system clock (50 MHz).
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx_valid  input  1  one-cycle pulse, new byte received from SPI slave.
REQ-006 SHALL have port rx_data  input  8  received byte, valid when rx_valid=1.
REQ-007 SHALL have port frame_end  input  1  one-cycle pulse, chip select deasserted (already synchronised to clk).
REQ-008 SHALL have port wr_en  output  1  memory write strobe.
REQ-009 SHALL have port wr_addr  output  ADDR_W  memory write address.
REQ-010 SHALL have port wr_data  output  8  memory write data.
REQ-011 SHALL have port rd_en  output  1  memory read strobe.
REQ-012 SHALL have port rd_addr  output  ADDR_W  memory read address.
REQ-013 SHALL have port rd_data  input  8  memory read data, valid exactly 1 cycle after rd_en.
REQ-014 SHALL have port tx_data  output  8  next byte for the SPI slave transmit register.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port err  output  1  one-cycle error pulse.
REQ-017 SHALL have port cmd_count  output  16  count of accepted commands, wraps 0xFFFF->0.

Function
REQ-018 SHALL implement states IDLE, ADDR, WDATA, RDATA, DISCARD; frame = bytes between frame_end pulses.
REQ-019 IDLE + rx_valid: opcode 0x01 (WRITE) or 0x02 (READ) -> ADDR, latch opcode, cmd_count+1; 0x00 (NOP) -> DISCARD, no count; any other -> DISCARD with err=1 next cycle.
REQ-020 ADDR + rx_valid: latch rx_data[ADDR_W-1:0] as pointer; WRITE -> WDATA; READ -> RDATA and rd_en=1, rd_addr=pointer on the following cycle.
REQ-021 WDATA + rx_valid: wr_en=1, wr_addr=pointer, wr_data=rx_data on the following cycle; pointer increments by 1 modulo 2^ADDR_W.
REQ-022 RDATA + rx_valid (dummy byte): pointer increments modulo 2^ADDR_W, then rd_en=1 with rd_addr=new pointer on the following cycle.
REQ-023 tx_data SHALL load rd_data on the cycle after every rd_en pulse and hold otherwise; first read byte is therefore ready 2 cycles after the address byte.
REQ-024 DISCARD SHALL ignore all rx_valid bytes with no outputs.
REQ-025 wr_en, rd_en, err SHALL be single-cycle pulses; wr_addr, wr_data, rd_addr hold last value between pulses.
REQ-026 frame_end in any state SHALL force next state IDLE; frame_end in ADDR (address never received) SHALL pulse err.
REQ-027 rx_valid and frame_end in the same cycle: byte SHALL be processed per current state (incl. write/read strobe), then state IDLE.
REQ-028 Timeout counter SHALL clear on every rx_valid and in IDLE, increment otherwise; reaching TIMEOUT SHALL force IDLE and pulse err.
REQ-029 rx_valid pulses arrive at most every 2 cycles; back-to-back behaviour beyond that is undefined.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, pointer 0, timeout 0, and all outputs 0 (wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_data, busy, err, cmd_count).
REQ-031 Reset mid-frame SHALL abandon the frame with no further strobes; first byte after release is treated as opcode.

Verification
REQ-032 Bytes 01,10,AA,BB,frame_end -> wr_en pulses (0x10,AA),(0x11,BB); cmd_count=1; busy low after frame_end.
REQ-033 Bytes 02,FE with memory FE=5A, FF=C3, 00=77; then 2 dummies -> rd_addr FE,FF,00 (wrap); tx_data 5A,C3,77.
REQ-034 Byte 7F then 3 bytes, frame_end -> one err pulse, no wr_en/rd_en, cmd_count unchanged.
REQ-035 Bytes 01,20 then no activity for TIMEOUT cycles -> err pulse, busy falls, next byte 01 accepted as opcode.
REQ-036 Bytes 01,30 then byte 99 coincident with frame_end -> wr_en (0x30,99), state IDLE next cycle.
REQ-037 rst_n low during WDATA after 2 writes -> all outputs 0 immediately, cmd_count=0, no strobes until new frame.
